// File: rtl/monitor_capture_if.sv
// Read-side handshake of the monitor capture block: sample word with valid/ready.
// The master drives data and valid; the slave (debug reader) drives ready.
interface monitor_capture_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int WORD_W = 2 * DATA_WIDTH + 1;

  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/monitor_capture.sv
// Trigger-armed capture buffer for datapath monitor taps: records DEPTH samples of
// {probe_s, probe_a, probe_b} after a mask/value match and plays them back over valid/ready.
module monitor_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] probe_a,
  input  logic [DATA_WIDTH-1:0] probe_b,
  input  logic                  probe_s,
  monitor_capture_if.master     rd,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] level_q, level_d;
  logic [WORD_W-1:0]    rd_data_q, rd_data_d;
  logic [WORD_W-1:0]    buf_q [DEPTH];
  logic [WORD_W-1:0]    sample;
  logic                 trig_hit;
  logic                 wr_en;
  logic                 last_wr;
  logic                 last_rd;

  assign sample     = {probe_s, probe_a, probe_b};
  assign trig_hit   = ((probe_a ^ trig_value) & trig_mask) == '0;
  assign last_wr    = (wr_ptr_q == PTR_W'(DEPTH - 1));
  assign last_rd    = (rd_ptr_q == PTR_W'(DEPTH - 1));
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (trig_hit) state_d = CAPTURE;
        CAPTURE: if (last_wr) state_d = READOUT;
        READOUT: if (rd.rd_ready && last_rd) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd.rd_valid = (state_q == READOUT);
    rd.rd_data  = rd_data_q;
    busy        = (state_q == ARMED) || (state_q == CAPTURE);
    done        = (state_q == READOUT);
    level       = level_q;
  end

  // The first readout word is fetched on the edge that stores the last sample,
  // so rd_data is already valid in the first READOUT cycle.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    wr_en     = 1'b0;
    if (abort) begin
      level_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            level_d  = level_q + 1'b1;
          end
        end
        CAPTURE: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          level_d  = level_q + 1'b1;
          if (last_wr) rd_data_d = buf_q[rd_ptr_q];
        end
        READOUT: begin
          if (rd.rd_ready) begin
            rd_ptr_d  = rd_ptr_nxt;
            level_d   = level_q - 1'b1;
            rd_data_d = buf_q[rd_ptr_nxt];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_ptr_q] <= sample;
  end

endmodule

// File: tb/tb_monitor_capture.sv
// Directed bench for monitor_capture: trigger, backpressure, masking, abort, arm filtering, async reset.
module tb_monitor_capture;

  logic       clk;
  logic       reset;
  logic       arm;
  logic       abort;
  logic [7:0] trig_value;
  logic [7:0] trig_mask;
  logic [7:0] probe_a;
  logic [7:0] probe_b;
  logic       probe_s;
  logic       busy;
  logic       done;
  logic [4:0] level;

  int n_cmp;
  int n_mis;

  monitor_capture_if #(.DATA_WIDTH(8)) rd_if ();

  monitor_capture #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .abort      (abort),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .probe_a    (probe_a),
    .probe_b    (probe_b),
    .probe_s    (probe_s),
    .rd         (rd_if.master),
    .busy       (busy),
    .done       (done),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] exp_word(input logic [7:0] a);
    return {a[0], a, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_probe(input logic [7:0] v);
    probe_a = v;
    probe_b = ~v;
    probe_s = v[0];
  endtask

  task automatic arm_with(input logic [7:0] mask, input logic [7:0] value);
    trig_mask  = mask;
    trig_value = value;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Counts probe_a up from start each cycle until done rises; returns edges used.
  task automatic capture_counter(input logic [7:0] start, output int ticks);
    set_probe(start);
    ticks = 0;
    while (!done && ticks < 100) begin
      tick();
      ticks++;
      if (!done) set_probe(probe_a + 8'd1);
    end
  endtask

  task automatic drain();
    rd_if.rd_ready = 1'b1;
    repeat (16) tick();
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({rd_if.rd_valid, busy, done} !== 3'b000) begin
      n_mis++;
      $display("[TB] FAIL reset_flags: got valid/busy/done=%b expected 000", {rd_if.rd_valid, busy, done});
    end
    n_cmp++;
    if (level !== 5'd0) begin
      n_mis++;
      $display("[TB] FAIL reset_level: got %0d expected 0", level);
    end
    n_cmp++;
    if (rd_if.rd_data !== 17'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_if.rd_data);
    end
  endtask

  task automatic test_basic_trigger();
    int t;
    arm_with(8'hFF, 8'h3C);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL basic_busy_armed: got %b expected 1", busy);
    end
    capture_counter(8'h30, t);
    n_cmp++;
    if (t !== 28) begin
      n_mis++;
      $display("[TB] FAIL basic_capture_edges: got %0d expected 28", t);
    end
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({rd_if.rd_valid, done, busy} !== 3'b110) begin
        n_mis++;
        $display("[TB] FAIL basic_flags[%0d]: got valid/done/busy=%b expected 110", i, {rd_if.rd_valid, done, busy});
      end
      n_cmp++;
      if (rd_if.rd_data !== exp_word(8'h3C + 8'(i))) begin
        n_mis++;
        $display("[TB] FAIL basic_word[%0d]: got %h expected %h", i, rd_if.rd_data, exp_word(8'h3C + 8'(i)));
      end
      n_cmp++;
      if (level !== 5'(16 - i)) begin
        n_mis++;
        $display("[TB] FAIL basic_level[%0d]: got %0d expected %0d", i, level, 16 - i);
      end
      tick();
    end
    rd_if.rd_ready = 1'b0;
    n_cmp++;
    if ({rd_if.rd_valid, done, level} !== 7'd0) begin
      n_mis++;
      $display("[TB] FAIL basic_end: got valid/done/level=%b/%b/%0d expected 0/0/0", rd_if.rd_valid, done, level);
    end
  endtask

  task automatic test_backpressure();
    int t;
    int idx;
    int cyc;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    arm_with(8'hFF, 8'h3C);
    capture_counter(8'h30, t);
    n_cmp++;
    if (t !== 28) begin
      n_mis++;
      $display("[TB] FAIL bp_capture_edges: got %0d expected 28", t);
    end
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 100) begin
      n_cmp++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_word(8'h3C + 8'(idx))) begin
        n_mis++;
        $display("[TB] FAIL bp_word[%0d]: got valid=%b data=%h expected valid=1 data=%h", idx, rd_if.rd_valid, rd_if.rd_data, exp_word(8'h3C + 8'(idx)));
      end
      n_cmp++;
      if (level !== 5'(16 - idx)) begin
        n_mis++;
        $display("[TB] FAIL bp_level[%0d]: got %0d expected %0d", idx, level, 16 - idx);
      end
      rd_if.rd_ready = pat[cyc % 4];
      tick();
      if (pat[cyc % 4]) idx++;
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    n_cmp++;
    if (idx !== 16 || rd_if.rd_valid !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL bp_end: got words=%0d valid=%b expected words=16 valid=0", idx, rd_if.rd_valid);
    end
  endtask

  task automatic test_immediate_trigger();
    int t;
    set_probe(8'h77);
    arm_with(8'h00, 8'h99);
    capture_counter(8'hA0, t);
    n_cmp++;
    if (t !== 16) begin
      n_mis++;
      $display("[TB] FAIL imm_capture_edges: got %0d expected 16", t);
    end
    n_cmp++;
    if (rd_if.rd_data !== exp_word(8'hA0)) begin
      n_mis++;
      $display("[TB] FAIL imm_first_word: got %h expected %h", rd_if.rd_data, exp_word(8'hA0));
    end
    drain();
  endtask

  task automatic test_nibble_trigger();
    int t;
    arm_with(8'h0F, 8'h05);
    capture_counter(8'hF8, t);
    n_cmp++;
    if (t !== 29) begin
      n_mis++;
      $display("[TB] FAIL nib_capture_edges: got %0d expected 29", t);
    end
    n_cmp++;
    if (rd_if.rd_data !== exp_word(8'h05)) begin
      n_mis++;
      $display("[TB] FAIL nib_first_word: got %h expected %h", rd_if.rd_data, exp_word(8'h05));
    end
    drain();
  endtask

  task automatic test_abort_capture();
    arm_with(8'h00, 8'h00);
    set_probe(8'h10);
    repeat (7) begin
      tick();
      set_probe(probe_a + 8'd1);
    end
    n_cmp++;
    if (level !== 5'd7 || busy !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL abcap_pre: got level=%0d busy=%b expected level=7 busy=1", level, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({level, busy, done, rd_if.rd_valid} !== 8'd0) begin
      n_mis++;
      $display("[TB] FAIL abcap_post: got level=%0d busy=%b done=%b valid=%b expected 0/0/0/0", level, busy, done, rd_if.rd_valid);
    end
    repeat (20) tick();
    n_cmp++;
    if (rd_if.rd_valid !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL abcap_later: got valid=%b busy=%b expected 0/0", rd_if.rd_valid, busy);
    end
  endtask

  task automatic test_abort_readout();
    int t;
    arm_with(8'h00, 8'h00);
    capture_counter(8'h40, t);
    rd_if.rd_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (level !== 5'd13 || rd_if.rd_data !== exp_word(8'h43)) begin
      n_mis++;
      $display("[TB] FAIL abrd_pre: got level=%0d data=%h expected level=13 data=%h", level, rd_if.rd_data, exp_word(8'h43));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rd_if.rd_ready = 1'b0;
    n_cmp++;
    if ({rd_if.rd_valid, done, level} !== 7'd0) begin
      n_mis++;
      $display("[TB] FAIL abrd_post: got valid=%b done=%b level=%0d expected 0/0/0", rd_if.rd_valid, done, level);
    end
  endtask

  task automatic test_abort_with_trigger();
    arm_with(8'hFF, 8'h55);
    set_probe(8'h55);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || level !== 5'd0) begin
      n_mis++;
      $display("[TB] FAIL abtrig_post: got busy=%b level=%0d expected 0/0", busy, level);
    end
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || level !== 5'd0 || done !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL abtrig_later: got busy=%b level=%0d done=%b expected 0/0/0", busy, level, done);
    end
  endtask

  task automatic test_arm_filter();
    int t;
    arm_with(8'h00, 8'h00);
    set_probe(8'h60);
    tick();
    set_probe(8'h61);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_cmp++;
    if (level !== 5'd2 || busy !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL armf_capture: got level=%0d busy=%b expected 2/1", level, busy);
    end
    capture_counter(8'h62, t);
    n_cmp++;
    if (t !== 14) begin
      n_mis++;
      $display("[TB] FAIL armf_capture_edges: got %0d expected 14", t);
    end
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_word(8'h60 + 8'(i))) begin
        n_mis++;
        $display("[TB] FAIL armf_word[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, rd_if.rd_valid, rd_if.rd_data, exp_word(8'h60 + 8'(i)));
      end
      arm = (i == 2);
      tick();
    end
    arm = 1'b0;
    rd_if.rd_ready = 1'b0;
    n_cmp++;
    if ({rd_if.rd_valid, busy, done} !== 3'b000) begin
      n_mis++;
      $display("[TB] FAIL armf_end: got valid/busy/done=%b expected 000", {rd_if.rd_valid, busy, done});
    end
  endtask

  task automatic test_arm_abort_idle();
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL armabort_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL armabort_hold: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int t;
    arm_with(8'h00, 8'h00);
    capture_counter(8'h20, t);
    rd_if.rd_ready = 1'b1;
    repeat (2) tick();
    rd_if.rd_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rd_if.rd_valid, done, busy} !== 3'b000 || level !== 5'd0) begin
      n_mis++;
      $display("[TB] FAIL areset_async: got valid/done/busy=%b level=%0d expected 000/0", {rd_if.rd_valid, done, busy}, level);
    end
    n_cmp++;
    if (rd_if.rd_data !== 17'h0) begin
      n_mis++;
      $display("[TB] FAIL areset_rd_data: got %h expected 0", rd_if.rd_data);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL areset_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
    arm_with(8'h00, 8'h00);
    capture_counter(8'h90, t);
    n_cmp++;
    if (t !== 16 || rd_if.rd_data !== exp_word(8'h90)) begin
      n_mis++;
      $display("[TB] FAIL areset_rearm: got edges=%0d data=%h expected 16/%h", t, rd_if.rd_data, exp_word(8'h90));
    end
    drain();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    trig_value = 8'h00;
    trig_mask = 8'h00;
    rd_if.rd_ready = 1'b0;
    set_probe(8'h00);
    #2;
    test_reset();
    test_basic_trigger();
    test_backpressure();
    test_immediate_trigger();
    test_nibble_trigger();
    test_abort_capture();
    test_abort_readout();
    test_abort_with_trigger();
    test_arm_filter();
    test_arm_abort_idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/monitor_capture.md
Name: monitor_capture

Overview:
- Capture-side consumer of the monitor taps that datapath top levels export (8-bit data probes plus a 1-bit select probe).
- Once armed, it waits for a mask/value trigger on probe_a, then records DEPTH consecutive samples of {probe_s, probe_a, probe_b} into an internal buffer.
- It then plays the samples back in order over a valid/ready read port to a debug reader.
- It sits beside the datapath top and taps only its *_monitor outputs. It never drives the datapath.

Parameters:
- DATA_WIDTH, 8, width of probe_a, probe_b, trig_value and trig_mask.
- DEPTH, 16, samples per capture. Power of two, at least 2.
- CNT_WIDTH, 5, width of the level output. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- arm  input  1  one-cycle pulse that starts a capture. Honoured in IDLE only.
- abort  input  1  returns the block to IDLE from any state.
- trig_value  input  DATA_WIDTH  trigger compare value.
- trig_mask  input  DATA_WIDTH  trigger bit mask. A 1 bit is compared.
- probe_a  input  DATA_WIDTH  monitored data bus A.
- probe_b  input  DATA_WIDTH  monitored data bus B.
- probe_s  input  1  monitored select bit.
- rd_data  output  2*DATA_WIDTH+1  sample word, packed {s, a, b}.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  reader accepts the word.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in READOUT.
- level  output  CNT_WIDTH  number of stored samples not yet read.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Write and read pointers, and level, clear to 0.
  - rd_valid=0, busy=0, done=0, rd_data=0.
  - Buffer contents are don't-care.
- FSM states: IDLE, ARMED, CAPTURE, READOUT.
- IDLE:
  - If arm=1 and abort=0, move to ARMED on the next edge and clear both pointers.
  - Otherwise hold.
- ARMED:
  - The trigger is hit when (probe_a & trig_mask) == (trig_value & trig_mask), evaluated combinationally every cycle.
  - trig_mask=0 means an immediate trigger.
  - On the trigger edge, the current probe word is written to entry 0, level becomes 1, and the state moves to CAPTURE.
  - The trigger sample is the first stored sample. There is zero latency from trigger to first sample.
- CAPTURE:
  - One sample is written per clock at the write pointer, and level increments.
  - The edge that writes entry DEPTH-1 moves the state to READOUT with level=DEPTH.
  - The trigger is not re-evaluated.
  - If DEPTH=2, the write after the trigger sample goes straight to READOUT.
- READOUT:
  - rd_valid=1 and rd_data=buffer[read pointer].
  - A word transfers on an edge where rd_valid & rd_ready. The read pointer then increments and level decrements.
  - rd_data and rd_valid stay stable while rd_valid=1 and rd_ready=0.
  - The transfer of entry DEPTH-1 moves the state to IDLE. rd_valid deasserts on that edge.
  - Full throughput: DEPTH transfers in DEPTH cycles when rd_ready is held high.
- rd_data timing: it is a registered output, or a read whose address is registered. The first word must be valid in the first READOUT cycle, so there are no idle cycles between CAPTURE and READOUT data.
- rd_valid is 0 outside READOUT. rd_data holds its last value outside READOUT and is don't-care to the reader.
- abort:
  - Has priority over every other event, including a trigger or transfer in the same cycle.
  - On the next edge: state goes to IDLE, level=0, rd_valid=0.
  - No partial readout is produced.
- arm outside IDLE is ignored.
- arm and abort together in IDLE: abort wins and the state stays IDLE.
- Reset asserted mid-capture or mid-readout forces IDLE immediately (asynchronously). The data is lost.
- Pointers are log2(DEPTH) bits and wrap naturally. level never exceeds DEPTH and never underflows.
- The probe inputs are sampled on clk with no synchronisers. They are in the same clock domain as the datapath.

Test Plan:
- Basic trigger: DEPTH=16, trig_mask=8'hFF, trig_value=8'h3C. Arm, drive probe_a as a counter from 0x30, with probe_b=~probe_a and probe_s=probe_a[0]. The trigger fires at 0x3C; readout with rd_ready=1 must return 16 words, probe_a 0x3C..0x4B in order, with matching b/s bits; done=1 for exactly 16 cycles; level steps 16→0.
- Backpressure: same capture, with rd_ready toggling 1,0,0,1. rd_data must hold across stalled cycles, no word may be lost or duplicated, and level decrements only on transfers.
- Masked / immediate trigger: trig_mask=8'h00. The capture starts on the cycle after arm, and the first sample equals the probe value at that edge.
  - Then trig_mask=8'h0F, trig_value=8'h05: the first stored probe_a has a low nibble of 5, and earlier values with a different low nibble are skipped.
- Abort: abort during CAPTURE at level=7 → next cycle IDLE, level=0, busy=0, with no rd_valid. Abort in READOUT after 3 transfers → rd_valid drops the next cycle. Abort asserted together with the trigger → no capture.
- Arm filtering: pulse arm during CAPTURE and during READOUT → no restart and the word order is unchanged. Arm together with abort in IDLE → remains IDLE.
- Async reset: assert reset mid-READOUT between clock edges. The outputs must clear before the next edge, and after release the block is in IDLE and re-arms cleanly.
